serial_adder_ctrl: RTL

- Bit-serial adder built around the single-bit full-adder cell.
- Loads two WIDTH-bit operands and a carry-in on a start pulse, then presents one bit pair per clock (LSB first) to the full-adder function.
- Holds the running carry in a flip-flop and accumulates sum bits in a shift register.
- Publishes the WIDTH-bit sum plus carry-out with a one-cycle done pulse.

---
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder: the requester drives
// operands/start, the adder returns status and the registered result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder step per clock, LSB first, with the running
// carry in a flop and the result published only on completion.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one bit pair added per clock, cnt counts processed bits
// DONE  | one-cycle done pulse; a new start is accepted here too
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_bit;
  logic             c_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    s_bit   = sa_q[0] ^ sb_q[0] ^ c_q;
    c_next  = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          ps_d    = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        c_d             = c_next;
        ps_d            = ps_q >> 1;
        ps_d[WIDTH-1]   = s_bit;
        sa_d            = sa_q >> 1;
        sb_d            = sb_q >> 1;
        cnt_d           = cnt_q + CW'(1);
        // Result ports only change here, so partial sums never leak out.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = ps_d;
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
